// File: rtl/float_signed_to_log_pipe_if.sv
`default_nettype none
// ============================================================================
// float_signed_to_log_pipe_if : valid/ready bus for the float-to-log converter
// Revision: 1.0
// ============================================================================
interface float_signed_to_log_pipe_if #(
   parameter int LANES   = 4,
   parameter int EXP_IN  = 10,
   parameter int FRAC_IN = 10,
   parameter int M       = 3,
   parameter int F       = 4
);
   localparam int c_in_w  = LANES * (3 + EXP_IN + FRAC_IN);
   localparam int c_out_w = LANES * (3 + M + F);

   logic               in_valid;
   logic               in_ready;
   logic [c_in_w-1:0]  in_data;
   logic               sat_max;
   logic               out_valid;
   logic               out_ready;
   logic [c_out_w-1:0] out_data;
   logic [LANES-1:0]   out_ovf;
   logic [LANES-1:0]   out_unf;

   modport master (
      output in_valid, in_data, sat_max, out_ready,
      input  in_ready, out_valid, out_data, out_ovf, out_unf
   );

   modport slave (
      input  in_valid, in_data, sat_max, out_ready,
      output in_ready, out_valid, out_data, out_ovf, out_unf
   );
endinterface
`default_nettype wire

// File: rtl/float_signed_to_log_pipe.sv
`default_nettype none
// ============================================================================
// float_signed_to_log_pipe : 2-stage multi-lane signed float -> log converter
// Optional statistics counters: define FLOAT_TO_LOG_STATS_EN
// Revision: 1.0
// ============================================================================
module float_signed_to_log_pipe #(
   parameter int LANES       = 4,
   parameter int EXP_IN      = 10,
   parameter int FRAC_IN     = 10,
   parameter int M           = 3,
   parameter int F           = 4,
   parameter bit SAT_DEFAULT = 1'b1
) (
   input  logic        clock_i,
   input  logic        reset_i,
`ifdef FLOAT_TO_LOG_STATS_EN
   input  logic        stat_clear_i,
   output logic [31:0] stat_ovf_cnt_o,
   output logic [31:0] stat_unf_cnt_o,
`endif
   float_signed_to_log_pipe_if.slave bus_io
);
   localparam int c_in_lw  = 3 + EXP_IN + FRAC_IN;
   localparam int c_out_lw = 3 + M + F;
   localparam int c_w      = ((EXP_IN > M) ? EXP_IN : M) + 1;
   localparam int c_n_thr  = 2 ** F;
   localparam int c_thr_w  = FRAC_IN + 2;
   localparam logic signed [c_w-1:0] c_e_max = c_w'((2 ** (M - 1)) - 1);
   localparam logic signed [c_w-1:0] c_e_min = c_w'(-(2 ** (M - 1)));

   logic               adv;
   logic               s1_valid_q;
   logic               sat_max_q;
   logic               out_valid_q;
   logic [c_thr_w-1:0] thr [c_n_thr];
   logic [LANES-1:0]   ovf_all;
   logic [LANES-1:0]   unf_all;

   assign adv              = !out_valid_q || bus_io.out_ready;
   assign bus_io.in_ready  = adv;
   assign bus_io.out_valid = out_valid_q;
   assign bus_io.out_ovf   = ovf_all;
   assign bus_io.out_unf   = unf_all;

   // Mantissa threshold for each log-fraction step: m >= thr[k] means
   // log2(m/2^FRAC_IN)*2^F rounds above k. Midpoints are irrational, so no ties.
   for (genvar k = 0; k < c_n_thr; k++) begin : g_thr
      localparam real c_t = (2.0 ** FRAC_IN) * (2.0 ** ((real'(k) + 0.5) / (2.0 ** F)));
      assign thr[k] = c_thr_w'($rtoi(c_t) + 1);
   end

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         s1_valid_q  <= 1'b0;
         sat_max_q   <= SAT_DEFAULT;
         out_valid_q <= 1'b0;
      end else if (adv) begin
         s1_valid_q  <= bus_io.in_valid;
         sat_max_q   <= bus_io.sat_max;
         out_valid_q <= s1_valid_q;
      end
   end

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      logic [c_in_lw-1:0]        lane;
      logic [FRAC_IN:0]          mant;
      logic signed [EXP_IN-1:0]  exp_in;
      logic [F:0]                lval;
      logic signed [c_w-1:0]     e_d;
      logic                      s1_inf_q, s1_zero_q, s1_sign_q;
      logic signed [c_w-1:0]     s1_exp_q;
      logic [F-1:0]              s1_frac_q;
      logic                      ovf_rng, unf_rng;
      logic [c_out_lw-1:0]       out_lane_d, out_lane_q;
      logic                      ovf_d, unf_d, ovf_q, unf_q;

      assign lane   = bus_io.in_data[l*c_in_lw +: c_in_lw];
      assign mant   = {1'b1, lane[FRAC_IN-1:0]};
      assign exp_in = lane[FRAC_IN +: EXP_IN];

      always_comb begin
         lval = '0;
         for (int k = 0; k < c_n_thr; k++) begin
            if ({1'b0, mant} >= thr[k]) lval = lval + (F+1)'(1);
         end
      end

      // lval tops out at 2^F, so its MSB is exactly the exponent carry.
      assign e_d = $signed({{(c_w-EXP_IN){exp_in[EXP_IN-1]}}, exp_in})
                 + $signed({{(c_w-1){1'b0}}, lval[F]});

      always_ff @(posedge clock_i) begin
         if (reset_i) begin
            s1_inf_q  <= 1'b0;
            s1_zero_q <= 1'b0;
            s1_sign_q <= 1'b0;
            s1_exp_q  <= '0;
            s1_frac_q <= '0;
         end else if (adv) begin
            s1_inf_q  <= lane[c_in_lw-1];
            s1_zero_q <= lane[c_in_lw-2];
            s1_sign_q <= lane[c_in_lw-3];
            s1_exp_q  <= e_d;
            s1_frac_q <= lval[F-1:0];
         end
      end

      assign ovf_rng = s1_exp_q > c_e_max;
      assign unf_rng = s1_exp_q < c_e_min;

      always_comb begin
         out_lane_d = '0;
         ovf_d      = ovf_rng;
         unf_d      = unf_rng;
         if (s1_inf_q) begin
            out_lane_d[c_out_lw-1] = 1'b1;
            ovf_d = 1'b0;
            unf_d = 1'b0;
         end else if (s1_zero_q) begin
            out_lane_d[c_out_lw-2] = 1'b1;
            ovf_d = 1'b0;
            unf_d = 1'b0;
         end else if (unf_rng) begin
            out_lane_d[c_out_lw-2] = 1'b1;
         end else if (ovf_rng && !sat_max_q) begin
            out_lane_d[c_out_lw-1] = 1'b1;
         end else if (ovf_rng) begin
            out_lane_d = {2'b00, s1_sign_q, c_e_max[M-1:0], {F{1'b1}}};
         end else begin
            out_lane_d = {2'b00, s1_sign_q, s1_exp_q[M-1:0], s1_frac_q};
         end
      end

      always_ff @(posedge clock_i) begin
         if (reset_i) begin
            out_lane_q <= '0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
         end else if (adv) begin
            out_lane_q <= out_lane_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
         end
      end

      assign bus_io.out_data[l*c_out_lw +: c_out_lw] = out_lane_q;
      assign ovf_all[l] = ovf_q;
      assign unf_all[l] = unf_q;
   end

`ifdef FLOAT_TO_LOG_STATS_EN
   localparam int c_pop_w = $clog2(LANES + 1);

   logic [c_pop_w-1:0] ovf_pop, unf_pop;
   logic [32:0]        ovf_sum, unf_sum;
   logic [31:0]        ovf_cnt_q, unf_cnt_q;

   always_comb begin
      ovf_pop = '0;
      unf_pop = '0;
      for (int l = 0; l < LANES; l++) begin
         ovf_pop = ovf_pop + c_pop_w'(ovf_all[l]);
         unf_pop = unf_pop + c_pop_w'(unf_all[l]);
      end
      ovf_sum = {1'b0, ovf_cnt_q} + 33'(ovf_pop);
      unf_sum = {1'b0, unf_cnt_q} + 33'(unf_pop);
   end

   always_ff @(posedge clock_i) begin
      if (reset_i || stat_clear_i) begin
         ovf_cnt_q <= '0;
         unf_cnt_q <= '0;
      end else if (out_valid_q && bus_io.out_ready) begin
         ovf_cnt_q <= ovf_sum[32] ? '1 : ovf_sum[31:0];
         unf_cnt_q <= unf_sum[32] ? '1 : unf_sum[31:0];
      end
   end

   assign stat_ovf_cnt_o = ovf_cnt_q;
   assign stat_unf_cnt_o = unf_cnt_q;
`else
   // Statistics counters are not built in this configuration.
`endif
endmodule
`default_nettype wire

// File: tb/tb_float_signed_to_log_pipe.sv
`default_nettype none
// ============================================================================
// tb_float_signed_to_log_pipe : directed self-checking bench
// Revision: 1.0
// ============================================================================
module tb_float_signed_to_log_pipe;
   typedef struct packed {
      logic [39:0] d;
      logic [3:0]  o;
      logic [3:0]  u;
   } beat_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_errors = 0;
   beat_t recv [$];
   beat_t expq [$];

   always #5 clk = ~clk;

   float_signed_to_log_pipe_if #(.LANES(4), .EXP_IN(10), .FRAC_IN(10), .M(3), .F(4)) bus ();
   float_signed_to_log_pipe_if #(.LANES(1), .EXP_IN(3),  .FRAC_IN(10), .M(3), .F(4)) bus2 ();

`ifdef FLOAT_TO_LOG_STATS_EN
   logic        stat_clear;
   logic [31:0] ovf_cnt, unf_cnt;
   logic        stat_clear2;
   logic [31:0] ovf_cnt2, unf_cnt2;
`endif

   float_signed_to_log_pipe #(
      .LANES(4), .EXP_IN(10), .FRAC_IN(10), .M(3), .F(4), .SAT_DEFAULT(1'b1)
   ) dut (
      .clock_i        (clk),
      .reset_i        (rst),
`ifdef FLOAT_TO_LOG_STATS_EN
      .stat_clear_i   (stat_clear),
      .stat_ovf_cnt_o (ovf_cnt),
      .stat_unf_cnt_o (unf_cnt),
`endif
      .bus_io         (bus)
   );

   float_signed_to_log_pipe #(
      .LANES(1), .EXP_IN(3), .FRAC_IN(10), .M(3), .F(4), .SAT_DEFAULT(1'b1)
   ) dut2 (
      .clock_i        (clk),
      .reset_i        (rst),
`ifdef FLOAT_TO_LOG_STATS_EN
      .stat_clear_i   (stat_clear2),
      .stat_ovf_cnt_o (ovf_cnt2),
      .stat_unf_cnt_o (unf_cnt2),
`endif
      .bus_io         (bus2)
   );

   function automatic logic [22:0] ilane(bit inf, bit zero, bit sign, int e, logic [9:0] fr);
      logic [9:0] ev = 10'(e);
      return {inf, zero, sign, ev, fr};
   endfunction

   function automatic logic [9:0] olane(bit inf, bit zero, bit sign, logic [2:0] e, logic [3:0] f);
      return {inf, zero, sign, e, f};
   endfunction

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic send(input logic [91:0] d, input bit s);
      bit ok = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      bus.sat_max  = s;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(negedge clk);
         ok = bus.in_ready;
         @(posedge clk);
         #1;
      end
      check("send_accept", ok, 1);
   endtask

   task automatic compare_queues(input string tag);
      check({tag, "_count"}, recv.size(), expq.size());
      for (int i = 0; i < recv.size() && i < expq.size(); i++) begin
         check($sformatf("%s_data%0d", tag, i), recv[i].d, expq[i].d);
         check($sformatf("%s_ovf%0d", tag, i),  recv[i].o, expq[i].o);
         check($sformatf("%s_unf%0d", tag, i),  recv[i].u, expq[i].u);
      end
   endtask

   task automatic drain(input int n);
      for (int i = 0; i < 30 && recv.size() < n; i++) @(posedge clk);
      repeat (4) @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (!rst && bus.out_valid && bus.out_ready)
         recv.push_back(beat_t'({bus.out_data, bus.out_ovf, bus.out_unf}));
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [39:0] held;
      bus.in_valid = 1'b0; bus.in_data = '0; bus.sat_max = 1'b0; bus.out_ready = 1'b1;
      bus2.in_valid = 1'b0; bus2.in_data = '0; bus2.sat_max = 1'b1; bus2.out_ready = 1'b1;
`ifdef FLOAT_TO_LOG_STATS_EN
      stat_clear = 1'b0;
      stat_clear2 = 1'b0;
`endif
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_out_data",  bus.out_data, 0);
      check("rst_out_ovf",   bus.out_ovf, 0);
      check("rst_out_unf",   bus.out_unf, 0);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("in_ready_after_rst", bus.in_ready, 1);

      // Beat A: exact latency and the basic mapping cases.
      bus.in_valid = 1'b1;
      bus.sat_max  = 1'b1;
      bus.in_data  = {ilane(1,0,0,0,0), ilane(0,0,0,-5,0), ilane(0,0,1,3,10'h3FF), ilane(0,0,0,1,0)};
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      check("lat_cycle1_valid", bus.out_valid, 0);
      @(posedge clk);
      #1;
      check("lat_cycle2_valid", bus.out_valid, 1);
      check("A_data", bus.out_data,
            {olane(1,0,0,0,0), olane(0,1,0,0,0), olane(0,0,1,3'd3,4'hF), olane(0,0,0,3'd1,0)});
      check("A_ovf", bus.out_ovf, 4'b0010);
      check("A_unf", bus.out_unf, 4'b0100);
      repeat (2) @(posedge clk);
      #1;
      recv.delete();
      expq.delete();

      // Beats B (sat off) and C (sat on) back to back.
      send({ilane(0,1,0,100,0), ilane(0,0,0,-4,0), ilane(0,0,0,3,10'h3FF), ilane(0,0,1,0,10'h200)}, 1'b0);
      expq.push_back(beat_t'({olane(0,1,0,0,0), olane(0,0,0,3'b100,0), olane(1,0,0,0,0),
                              olane(0,0,1,3'd0,4'd9), 4'b0010, 4'b0000}));
      send({ilane(0,0,1,-512,0), ilane(0,0,1,-5,10'h3FF), ilane(0,0,0,4,0), ilane(0,0,0,3,0)}, 1'b1);
      expq.push_back(beat_t'({olane(0,1,0,0,0), olane(0,0,1,3'b100,0), olane(0,0,0,3'd3,4'hF),
                              olane(0,0,0,3'd3,0), 4'b0010, 4'b1000}));
      bus.in_valid = 1'b0;
      drain(2);
      compare_queues("BC");

      // Five-beat stream with a 3-cycle downstream stall.
      recv.delete();
      expq.delete();
      fork
         begin
            for (int k = 0; k < 5; k++) begin
               send({ilane(0,1,0,0,0), ilane(0,1,0,0,0), ilane(0,1,0,0,0), ilane(0,0,0,k-2,0)}, 1'b1);
               expq.push_back(beat_t'({olane(0,1,0,0,0), olane(0,1,0,0,0), olane(0,1,0,0,0),
                                       olane(0,0,0,3'(k-2),0), 4'b0000, 4'b0000}));
            end
            bus.in_valid = 1'b0;
         end
         begin
            for (int i = 0; i < 20 && !bus.out_valid; i++) @(negedge clk);
            @(posedge clk);
            #1;
            bus.out_ready = 1'b0;
            held = bus.out_data;
            for (int i = 0; i < 3; i++) begin
               @(negedge clk);
               check($sformatf("stall_hold%0d", i),  bus.out_data, held);
               check($sformatf("stall_ready%0d", i), bus.in_ready, 0);
               check($sformatf("stall_valid%0d", i), bus.out_valid, 1);
               @(posedge clk);
            end
            #1;
            bus.out_ready = 1'b1;
         end
      join
      drain(5);
      compare_queues("stream");

      // Reset with two beats in flight.
      send({4{ilane(0,0,0,1,0)}}, 1'b1);
      send({4{ilane(0,0,0,2,0)}}, 1'b1);
      bus.in_valid = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("midrst_out_valid", bus.out_valid, 0);
      rst = 1'b0;
      recv.delete();
      repeat (6) @(posedge clk);
      #1;
      check("midrst_no_stale", recv.size(), 0);
      check("midrst_in_ready", bus.in_ready, 1);

`ifdef FLOAT_TO_LOG_STATS_EN
      check("stat_ovf_zero", ovf_cnt, 0);
      send({ilane(0,0,0,4,0), ilane(0,0,0,4,0), ilane(0,0,0,4,0), ilane(0,0,0,0,0)}, 1'b1);
      bus.in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("stat_ovf_cnt3", ovf_cnt, 3);
      check("stat_unf_cnt0", unf_cnt, 0);
      stat_clear = 1'b1;
      @(posedge clk);
      #1;
      stat_clear = 1'b0;
      check("stat_ovf_clear", ovf_cnt, 0);
`endif

      // Narrow instance where EXP_IN equals M.
      bus2.in_valid = 1'b1;
      bus2.sat_max  = 1'b1;
      bus2.in_data  = {3'b000, 3'd3, 10'h3FF};
      repeat (2) @(posedge clk);
      #1;
      check("eq_sat_data", bus2.out_data, olane(0,0,0,3'd3,4'hF));
      check("eq_sat_ovf",  bus2.out_ovf, 1);
      bus2.sat_max = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("eq_inf_data", bus2.out_data, olane(1,0,0,0,0));
      check("eq_inf_ovf",  bus2.out_ovf, 1);
      bus2.in_data = {3'b000, 3'b100, 10'h000};
      repeat (2) @(posedge clk);
      #1;
      check("eq_min_data", bus2.out_data, olane(0,0,0,3'b100,0));
      check("eq_min_unf",  bus2.out_unf, 0);
      bus2.in_data = {3'b001, 3'b100, 10'h3FF};
      repeat (2) @(posedge clk);
      #1;
      check("eq_carry_data", bus2.out_data, olane(0,0,1,3'b101,0));
      bus2.in_valid = 1'b0;

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/float_signed_to_log_pipe.md
Name: float_signed_to_log_pipe

Overview:
- Multi-lane, pipelined linear-float to log-number converter with valid/ready flow control.
- Each lane maps a pre-rounded signed float (exp + fraction) to an unpacked log number (signed integer exp + F-bit log fraction).
- Saturation mode is selectable at run time, not only at elaboration.
- Fixes exponent-range checking for all EXP_IN/M combinations, including EXP_IN == M.
- Sits between the linear accumulator output and the log-domain requantiser.

Parameters:
- LANES, 4, number of independent conversion lanes sharing one handshake.
- EXP_IN, 10, input signed exponent width.
- FRAC_IN, 10, input fraction width (hidden one excluded).
- M, 3, output signed log exponent width.
- F, 4, output log fraction width.
- SAT_DEFAULT, 1, value of sat_max_q after reset.

Ports:
- clock  in  1  sole clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block accepts the beat this cycle.
- in_data  in  LANES*(3+EXP_IN+FRAC_IN)  per lane, MSB first: {isInf, isZero, sign, exp[EXP_IN-1:0] signed, frac[FRAC_IN-1:0]}; lane 0 in the LSBs.
- sat_max  in  1  saturation mode, sampled with each accepted beat.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts the beat.
- out_data  out  LANES*(3+M+F)  per lane: {isInf, isZero, sign, signedLogExp[M-1:0], logFrac[F-1:0]}.
- out_ovf  out  LANES  per-lane overflow flag, aligned with out_data.
- out_unf  out  LANES  per-lane underflow flag, aligned with out_data.

Behaviour:
- Pipeline: 2 register stages. S1 = log2 map plus exponent round. S2 = range check, select and pack.
- Latency: 2 cycles from accepted input to out_valid.
- Advance: adv = !out_valid || out_ready. in_ready = adv (combinational from out_ready).
- Both stages load when adv is high; no bubbles are inserted; throughput is 1 beat per cycle.
- Stall: while out_valid && !out_ready, out_data, out_ovf and out_unf hold stable and no stage changes.
- Reset: S1/S2 valid bits = 0. out_valid = 0; out_data, out_ovf, out_unf = 0. sat_max_q = SAT_DEFAULT.
  - Reset mid-stream discards in-flight beats.
  - in_ready is 1 in the first cycle after reset deasserts.
- Log map: L = round-to-nearest-even(log2(1 + frac/2^FRAC_IN) * 2^F), using the existing Log2Map table.
  - If L == 2^F, then carry = 1 and logFrac = 0; otherwise carry = 0 and logFrac = L[F-1:0].
- Exponent arithmetic: E = sign-extend(exp) + carry, computed in W = max(EXP_IN, M) + 1 bits signed, so no wrap.
- Range flags:
  - ovf = E > 2^(M-1) - 1.
  - unf = E < -2^(M-1).
  - Otherwise signedLogExp = E[M-1:0].
- Result priority per lane:
  1. isInf input → inf (isInf=1, all other fields 0).
  2. isZero input → zero (isZero=1, all other fields 0).
  3. unf → zero.
  4. ovf with sat_max_q=0 → inf.
  5. ovf with sat_max_q=1 → max: sign kept, exp = 2^(M-1)-1, logFrac all ones.
  6. Otherwise normal: sign, E, logFrac.
- Flag reporting: out_ovf/out_unf reflect the E-range checks only. Both are 0 when the input isInf or isZero.
- sat_max is registered alongside each beat, so a mode change applies per beat with no cross-beat effect.
- Lanes are independent; one lane overflowing does not affect the others.

Optional Feature:
- Macro: FLOAT_TO_LOG_STATS_EN.
- When defined, the block adds:
  - Outputs stat_ovf_cnt [31:0] and stat_unf_cnt [31:0].
  - Input stat_clear [0:0].
- Each counter adds the popcount of out_ovf (or out_unf) on every out_valid && out_ready handshake.
- Counters saturate at 2^32-1 and reset to 0.
- stat_clear zeroes both counters the next cycle; clear wins over a simultaneous increment.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Test Plan:
- Defaults, lane 0 = {0,0,0,exp=1,frac=0} → out {0,0,0,1,0}, ovf=0, unf=0, out_valid exactly 2 cycles after acceptance.
- exp=3, frac=0x3FF (L rounds to 16, carry) with sat_max=1 → {0,0,sign,3,0xF}, ovf=1. Same beat with sat_max=0 → inf, ovf=1.
- exp=-5, frac=0 → zero, unf=1. exp=-4, frac=0 → {.., exp=-4, frac=0}, unf=0. An isInf=1 lane alongside → inf, flags 0.
- Instance with EXP_IN=M=3: exp=3, frac=0x3FF → ovf=1 and saturated max (no wrap to -4).
- Backpressure: stream 5 back-to-back beats, hold out_ready=0 for 3 cycles mid-stream → outputs held stable, in_ready=0 while stalled, all 5 beats delivered in order with none dropped or duplicated.
- Assert reset with 2 beats in flight → out_valid=0 next cycle and no stale beats appear afterwards. With FLOAT_TO_LOG_STATS_EN, 3 ovf lanes in one beat → stat_ovf_cnt=3; then stat_clear → 0.
